// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the pipeline M stage
// and an external DMA/debug requester. Each access occupies the memory for LAT
// cycles. The pipeline has fixed priority, but once the DMA has lost STARVE_MAX
// arbitrations in a row it wins the next one.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   m_req/m_we/m_addr/
//   m_wdata/m_pc           pipeline M-stage request (held while m_stall=1)
//   m_stall                freeze F/D/E/M this cycle
//   m_rdata                load data, valid in the pipeline completion cycle
//   dma_req/dma_we/
//   dma_addr/dma_wdata     DMA request (held until dma_done)
//   dma_gnt                one-cycle pulse: DMA request accepted
//   dma_done               one-cycle pulse: DMA access complete
//   dma_rdata              DMA read data, valid with dma_done
//   mem_en/mem_we/
//   mem_addr/mem_wdata/
//   mem_pc                 DM command, driven from latched registers
//   mem_rdata              DM read data, valid on the last busy cycle
//
// state  | meaning
// IDLE   | memory free; arbitrate between pipeline and DMA
// BUSY_M | pipeline access in flight, cnt counts busy cycles
// BUSY_D | DMA access in flight, cnt counts busy cycles

module dm_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [31:0] m_pc,
  output logic        m_stall,
  output logic [31:0] m_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_M = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  localparam int             CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(LAT - 1);
  localparam logic [3:0]     SMAX     = 4'(STARVE_MAX);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    scnt;
  logic          we_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   pc_reg;

  logic busy;
  logic last;
  logic grant_m;
  logic grant_d;
  logic m_done;

  assign busy = (state == S_BUSY_M) || (state == S_BUSY_D);
  assign last = (cnt == CNT_LAST);

  // Pipeline wins unless the DMA has already lost STARVE_MAX times in a row.
  assign grant_m = (state == S_IDLE) && m_req && (!dma_req || (scnt < SMAX));
  assign grant_d = (state == S_IDLE) && dma_req && !grant_m;

  assign m_done   = (state == S_BUSY_M) && last;
  assign dma_done = (state == S_BUSY_D) && last;
  assign dma_gnt  = grant_d;

  // Stall covers waiting in IDLE, waiting behind a DMA access, and the busy
  // cycles of the pipeline's own access up to (not including) completion.
  assign m_stall = m_req && !m_done;

  assign m_rdata   = m_done   ? mem_rdata : 32'h0;
  assign dma_rdata = dma_done ? mem_rdata : 32'h0;

  // Write strobe only on the first busy cycle so each store writes once.
  assign mem_en    = busy;
  assign mem_we    = busy && we_reg && (cnt == '0);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_pc    = pc_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      scnt      <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      pc_reg    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (grant_m) begin
            state     <= S_BUSY_M;
            we_reg    <= m_we;
            addr_reg  <= m_addr;
            wdata_reg <= m_wdata;
            pc_reg    <= m_pc;
            if (dma_req && (scnt < SMAX)) begin
              scnt <= scnt + 4'd1;
            end
          end else if (grant_d) begin
            state     <= S_BUSY_D;
            we_reg    <= dma_we;
            addr_reg  <= dma_addr;
            wdata_reg <= dma_wdata;
            pc_reg    <= '0;
            scnt      <= '0;
          end
        end
        S_BUSY_M, S_BUSY_D: begin
          // Always return to IDLE after completion; no back-to-back grant.
          if (last) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized
// traffic checked against a word-level memory model and a priority model.

module tb_dm_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata, m_pc;
  logic        m_stall;
  logic [31:0] m_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_done;
  logic [31:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;

  logic        ovr_en;
  logic [31:0] ovr_val;
  logic [31:0] dm      [0:63];
  logic [31:0] ref_mem [0:63];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port memory behind the main instance.
  always @(posedge clk) if (mem_en && mem_we) dm[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = ovr_en ? ovr_val : dm[mem_addr[7:2]];

  dm_arbiter #(.LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_pc(m_pc),
    .m_stall(m_stall), .m_rdata(m_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_pc(mem_pc), .mem_rdata(mem_rdata)
  );

  // Latency sweep instances: index 0 -> LAT=1, index 1 -> LAT=4.
  logic        l_req    [2];
  logic [31:0] l_addr   [2];
  logic        l_stall  [2];
  logic [31:0] l_rdata  [2];
  logic        l_dgnt   [2];
  logic        l_ddone  [2];
  logic [31:0] l_drdata [2];
  logic        l_en     [2];
  logic        l_we     [2];
  logic [31:0] l_maddr  [2];
  logic [31:0] l_mwdata [2];
  logic [31:0] l_mpc    [2];

  dm_arbiter #(.LAT(1), .STARVE_MAX(SMAX)) u_lat1 (
    .clk(clk), .reset(reset),
    .m_req(l_req[0]), .m_we(1'b0), .m_addr(l_addr[0]), .m_wdata(32'h0), .m_pc(32'h0),
    .m_stall(l_stall[0]), .m_rdata(l_rdata[0]),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_gnt(l_dgnt[0]), .dma_done(l_ddone[0]), .dma_rdata(l_drdata[0]),
    .mem_en(l_en[0]), .mem_we(l_we[0]), .mem_addr(l_maddr[0]), .mem_wdata(l_mwdata[0]),
    .mem_pc(l_mpc[0]), .mem_rdata(l_maddr[0] ^ 32'hFFFF_0000)
  );

  dm_arbiter #(.LAT(4), .STARVE_MAX(SMAX)) u_lat4 (
    .clk(clk), .reset(reset),
    .m_req(l_req[1]), .m_we(1'b0), .m_addr(l_addr[1]), .m_wdata(32'h0), .m_pc(32'h0),
    .m_stall(l_stall[1]), .m_rdata(l_rdata[1]),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_gnt(l_dgnt[1]), .dma_done(l_ddone[1]), .dma_rdata(l_drdata[1]),
    .mem_en(l_en[1]), .mem_we(l_we[1]), .mem_addr(l_maddr[1]), .mem_wdata(l_mwdata[1]),
    .mem_pc(l_mpc[1]), .mem_rdata(l_maddr[1] ^ 32'hFFFF_0000)
  );

  // Reference read/write against the shadow memory; returns the old word.
  function automatic logic [31:0] model_op(input logic we, input int idx, input logic [31:0] wd);
    logic [31:0] r;
    r = ref_mem[idx];
    if (we) ref_mem[idx] = wd;
    return r;
  endfunction

  // Runs one pipeline access from an idle arbiter and measures it.
  task automatic m_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, output int stall_n, output int we_n,
                          output logic [31:0] rd, output logic [31:0] wa,
                          output logic [31:0] wd, output logic [31:0] wp, output bit tmo);
    @(posedge clk); #1;
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_pc = pc;
    stall_n = 0; we_n = 0; rd = '0; wa = '0; wd = '0; wp = '0; tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we) begin we_n++; wa = mem_addr; wd = mem_wdata; wp = mem_pc; end
      if (m_stall) stall_n++;
      else begin rd = m_rdata; tmo = 1'b0; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    m_req = 1'b0; m_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ovr_en = 1'b0; ovr_val = '0;
    m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_pc = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    for (int k = 0; k < 2; k++) begin l_req[k] = 1'b0; l_addr[k] = '0; end
    @(negedge clk);
    total++;
    if ({m_stall, dma_gnt, dma_done, mem_en, mem_we} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {m_stall, dma_gnt, dma_done, mem_en, mem_we});
    end
    total++;
    if ({mem_addr, mem_wdata, mem_pc, m_rdata, dma_rdata} !== 160'h0) begin
      bad++; $display("FAIL reset_data got addr=%h wdata=%h pc=%h exp all 0", mem_addr, mem_wdata, mem_pc);
    end
    m_req = 1'b1; #1;
    total++;
    if (m_stall !== 1'b1 || mem_en !== 1'b0) begin
      bad++; $display("FAIL reset_stall_follows_req got stall=%b en=%b exp stall=1 en=0", m_stall, mem_en);
    end
    m_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_fill();
    int sn, wn; logic [31:0] rd, wa, wd, wp, v; bit tmo;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      m_access(1'b1, 32'(i * 4), v, 32'h1000 + 32'(i * 4), sn, wn, rd, wa, wd, wp, tmo);
      void'(model_op(1'b1, i, v));
      total++;
      if (tmo || wn != 1 || wa !== 32'(i * 4) || wd !== v) begin
        bad++; $display("FAIL fill_store[%0d] got writes=%0d addr=%h data=%h tmo=%0d exp 1 write %h/%h", i, wn, wa, wd, tmo, i * 4, v);
      end
    end
  endtask

  task automatic test_load();
    int sn, wn; logic [31:0] rd, wa, wd, wp; bit tmo;
    ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
    m_access(1'b0, 32'h10, 32'h0, 32'h2000, sn, wn, rd, wa, wd, wp, tmo);
    ovr_en = 1'b0;
    total++;
    if (tmo || sn != LAT) begin bad++; $display("FAIL load_stall_len got=%0d tmo=%0d exp=%0d", sn, tmo, LAT); end
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
    total++;
    if (wn != 0) begin bad++; $display("FAIL load_no_write got=%0d exp=0", wn); end
    @(negedge clk);
    total++;
    if (mem_en !== 1'b0 || mem_addr !== 32'h10 || $isunknown(m_rdata)) begin
      bad++; $display("FAIL load_idle_hold got en=%b addr=%h exp en=0 addr=00000010", mem_en, mem_addr);
    end
  endtask

  task automatic test_store();
    int sn, wn; logic [31:0] rd, wa, wd, wp; bit tmo;
    m_access(1'b1, 32'h4, 32'h1234_5678, 32'h3000, sn, wn, rd, wa, wd, wp, tmo);
    void'(model_op(1'b1, 1, 32'h1234_5678));
    total++;
    if (tmo || wn != 1) begin bad++; $display("FAIL store_write_count got=%0d exp=1", wn); end
    total++;
    if (wa !== 32'h4 || wd !== 32'h1234_5678 || wp !== 32'h3000) begin
      bad++; $display("FAIL store_cmd got addr=%h data=%h pc=%h exp 00000004/12345678/00003000", wa, wd, wp);
    end
    total++;
    if (sn != LAT) begin bad++; $display("FAIL store_stall_len got=%0d exp=%0d", sn, LAT); end
    m_access(1'b0, 32'h4, 32'h0, 32'h3004, sn, wn, rd, wa, wd, wp, tmo);
    total++;
    if (tmo || rd !== 32'h1234_5678) begin bad++; $display("FAIL store_readback got=%h exp=12345678", rd); end
  endtask

  task automatic test_dma_read();
    int t, mdone; logic [31:0] md;
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20; dma_wdata = 32'h5555_AAAA;
    t = cyc;
    @(negedge clk);
    total++;
    if (dma_gnt !== 1'b1) begin bad++; $display("FAIL dma_gnt_t got=%b exp=1", dma_gnt); end
    @(posedge clk); #1;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h30; m_pc = 32'h4000;
    @(negedge clk);
    total++;
    if (m_stall !== 1'b1 || dma_gnt !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h20 || mem_pc !== 32'h0) begin
      bad++; $display("FAIL dma_busy got stall=%b gnt=%b en=%b addr=%h pc=%h exp 1/0/1/00000020/0", m_stall, dma_gnt, mem_en, mem_addr, mem_pc);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (dma_done !== 1'b1 || dma_rdata !== ref_mem[8] || m_stall !== 1'b1) begin
      bad++; $display("FAIL dma_done_t2 got done=%b data=%h stall=%b exp 1/%h/1", dma_done, dma_rdata, m_stall, ref_mem[8]);
    end
    @(posedge clk); #1;
    dma_req = 1'b0;
    mdone = -1; md = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!m_stall) begin mdone = cyc; md = m_rdata; break; end
      @(posedge clk); #1;
    end
    total++;
    if (mdone - t != LAT + 3) begin bad++; $display("FAIL dma_then_m_done got=t+%0d exp=t+%0d", mdone - t, LAT + 3); end
    total++;
    if (md !== ref_mem[12]) begin bad++; $display("FAIL dma_then_m_rdata got=%h exp=%h", md, ref_mem[12]); end
    @(posedge clk); #1;
    m_req = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int sn, wn; logic [31:0] rd, wa, wd, wp; bit tmo;
    @(posedge clk); #1;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h8; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'hC;
    @(negedge clk);
    total++;
    if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rst_busy_priority got gnt=%b exp=0", dma_gnt); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; dma_req = 1'b0;
    @(negedge clk);
    total++;
    if (m_stall !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
      bad++; $display("FAIL rst_busy_abort got stall=%b en=%b we=%b addr=%h exp 1/0/0/0", m_stall, mem_en, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0; m_req = 1'b0;
    m_access(1'b0, 32'h8, 32'h0, 32'h5000, sn, wn, rd, wa, wd, wp, tmo);
    total++;
    if (tmo || sn != LAT || rd !== ref_mem[2]) begin
      bad++; $display("FAIL rst_busy_after got stall=%0d data=%h exp %0d/%h", sn, rd, LAT, ref_mem[2]);
    end
  endtask

  task automatic test_starvation();
    bit exp_d [10]; bit got_d [10]; int got_c [10]; int n, s, gnt_c;
    s = 0;
    for (int k = 0; k < 10; k++) begin
      if (s < SMAX) begin exp_d[k] = 1'b0; s++; end
      else begin exp_d[k] = 1'b1; s = 0; end
      got_d[k] = 1'b0; got_c[k] = 0;
    end
    @(posedge clk); #1;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h40;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h44;
    n = 0; gnt_c = -100;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (dma_gnt) gnt_c = cyc;
      if (!m_stall) begin
        got_d[n] = 1'b0; got_c[n] = cyc;
        total++;
        if (m_rdata !== ref_mem[16]) begin bad++; $display("FAIL starve_m_rdata[%0d] got=%h exp=%h", n, m_rdata, ref_mem[16]); end
        n++;
      end else if (dma_done) begin
        got_d[n] = 1'b1; got_c[n] = cyc;
        total++;
        if (dma_rdata !== ref_mem[17] || cyc - gnt_c != LAT) begin
          bad++; $display("FAIL starve_dma[%0d] got data=%h lat=%0d exp %h/%0d", n, dma_rdata, cyc - gnt_c, ref_mem[17], LAT);
        end
        n++;
      end
      @(posedge clk); #1;
    end
    m_req = 1'b0; dma_req = 1'b0;
    total++;
    if (n != 10) begin bad++; $display("FAIL starve_count got=%0d exp=10", n); end
    for (int k = 0; k < n; k++) begin
      total++;
      if (got_d[k] !== exp_d[k]) begin bad++; $display("FAIL starve_order[%0d] got dma=%0d exp dma=%0d", k, got_d[k], exp_d[k]); end
      if (k > 0) begin
        total++;
        if (got_c[k] - got_c[k-1] != LAT + 1) begin
          bad++; $display("FAIL starve_spacing[%0d] got=%0d exp=%0d", k, got_c[k] - got_c[k-1], LAT + 1);
        end
      end
    end
  endtask

  task automatic test_random();
    int kind, s, ma, da, exp_wr, wcount, gcount, first;
    bit dom, dod, mfirst, pm, pd, mnow, dnow;
    logic mwe, dwe;
    logic [31:0] mwd, mpc, dwd, exp_m, exp_d, got_m, got_d;
    s = 0;
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 2));
      dom = (kind != 1); dod = (kind != 0);
      mwe = 1'($urandom_range(0, 1)); ma = int'($urandom_range(0, 63)); mwd = $urandom; mpc = $urandom;
      dwe = 1'($urandom_range(0, 1)); da = int'($urandom_range(0, 63)); dwd = $urandom;
      mfirst = 1'b1;
      if (dom && dod) mfirst = (s < SMAX);
      if (dod) s = 0;
      exp_wr = ((dom && mwe) ? 1 : 0) + ((dod && dwe) ? 1 : 0);
      exp_m = '0; exp_d = '0;
      if (mfirst) begin
        if (dom) exp_m = model_op(mwe, ma, mwd);
        if (dod) exp_d = model_op(dwe, da, dwd);
      end else begin
        exp_d = model_op(dwe, da, dwd);
        exp_m = model_op(mwe, ma, mwd);
      end
      @(posedge clk); #1;
      m_req = dom; m_we = mwe; m_addr = 32'(ma * 4); m_wdata = mwd; m_pc = mpc;
      dma_req = dod; dma_we = dwe; dma_addr = 32'(da * 4); dma_wdata = dwd;
      pm = dom; pd = dod; first = -1; wcount = 0; gcount = 0; got_m = '0; got_d = '0;
      for (int c = 0; c < 30 && (pm || pd); c++) begin
        @(negedge clk);
        if (mem_we) wcount++;
        if (dma_gnt) gcount++;
        mnow = 1'b0; dnow = 1'b0;
        if (pm && !m_stall) begin got_m = m_rdata; mnow = 1'b1; if (first < 0) first = 0; end
        if (pd && dma_done) begin got_d = dma_rdata; dnow = 1'b1; if (first < 0) first = 1; end
        @(posedge clk); #1;
        if (mnow) begin pm = 1'b0; m_req = 1'b0; end
        if (dnow) begin pd = 1'b0; dma_req = 1'b0; end
      end
      m_req = 1'b0; dma_req = 1'b0;
      total++;
      if (pm || pd) begin bad++; $display("FAIL rand_timeout[%0d] got pending m=%0d d=%0d exp none", it, pm, pd); end
      if (dom && dod) begin
        total++;
        if (first != (mfirst ? 0 : 1)) begin bad++; $display("FAIL rand_order[%0d] got first=%0d exp=%0d", it, first, mfirst ? 0 : 1); end
      end
      if (dom && !mwe) begin
        total++;
        if (got_m !== exp_m) begin bad++; $display("FAIL rand_m_rdata[%0d] got=%h exp=%h", it, got_m, exp_m); end
      end
      if (dod && !dwe) begin
        total++;
        if (got_d !== exp_d) begin bad++; $display("FAIL rand_dma_rdata[%0d] got=%h exp=%h", it, got_d, exp_d); end
      end
      total++;
      if (wcount != exp_wr || gcount != (dod ? 1 : 0)) begin
        bad++; $display("FAIL rand_counts[%0d] got writes=%0d gnts=%0d exp %0d/%0d", it, wcount, gcount, exp_wr, dod ? 1 : 0);
      end
    end
  endtask

  task automatic test_lat_sweep();
    int lat, n, run, gap;
    bit seen_done, done_now;
    logic side;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 1 : 4;
      @(posedge clk); #1;
      l_req[k] = 1'b1; l_addr[k] = 32'h100;
      n = 0; run = 0; gap = 0; seen_done = 1'b0; side = 1'b0;
      for (int c = 0; c < 60 && n < 3; c++) begin
        @(negedge clk);
        side = side | l_dgnt[k] | l_ddone[k] | l_we[k] | (|l_drdata[k]) | (|l_mwdata[k]) | (|l_mpc[k]);
        if (l_en[k]) begin
          if (seen_done) begin
            total++;
            if (gap != 1) begin bad++; $display("FAIL sweep_gap lat=%0d got=%0d exp=1", lat, gap); end
            seen_done = 1'b0;
          end
        end else if (seen_done) begin
          gap++;
        end
        done_now = 1'b0;
        if (l_stall[k]) begin
          run++;
        end else begin
          total++;
          if (run != lat) begin bad++; $display("FAIL sweep_stall lat=%0d got=%0d exp=%0d", lat, run, lat); end
          total++;
          if (l_rdata[k] !== (l_addr[k] ^ 32'hFFFF_0000)) begin
            bad++; $display("FAIL sweep_rdata lat=%0d got=%h exp=%h", lat, l_rdata[k], l_addr[k] ^ 32'hFFFF_0000);
          end
          n++; run = 0; gap = 0; seen_done = 1'b1; done_now = 1'b1;
        end
        @(posedge clk); #1;
        if (done_now) l_addr[k] = l_addr[k] + 32'h4;
      end
      l_req[k] = 1'b0;
      total++;
      if (n != 3) begin bad++; $display("FAIL sweep_count lat=%0d got=%0d exp=3", lat, n); end
      total++;
      if (side !== 1'b0) begin bad++; $display("FAIL sweep_side lat=%0d got=%b exp=0", lat, side); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load();
    test_store();
    test_dma_read();
    test_reset_mid_busy();
    test_starvation();
    test_random();
    test_lat_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single-port data memory (DM) between the pipeline M stage and an external DMA/debug requester, and sequences each access over a fixed memory latency. It sits between the M-stage memory request signals and the DM instance. It stalls the pipeline while a pipeline access is in flight or the DMA holds the memory. Fixed priority goes to the pipeline, with a starvation bound for DMA.

## Interface
- LAT, 2: DM access latency in cycles, ≥1; each access occupies the memory for LAT cycles.
- STARVE_MAX, 4: consecutive lost arbitrations after which DMA wins, 1..15.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- m_req  in  1  pipeline memory access request (load or store), level; held while m_stall=1.
- m_we  in  1  pipeline store (1) / load (0).
- m_addr  in  32  pipeline byte address (ALU result).
- m_wdata  in  32  pipeline store data (rt value).
- m_pc  in  32  PC of the M-stage instruction, forwarded to DM for store logging.
- m_stall  out  1  freeze F/D/E/M stages this cycle.
- m_rdata  out  32  load data; valid only in the m_done cycle.
- dma_req, dma_we  in  1 each  DMA request level / write enable; held until dma_done.
- dma_addr, dma_wdata  in  32 each  DMA address / write data.
- dma_gnt  out  1  one-cycle pulse: DMA request accepted.
- dma_done  out  1  one-cycle pulse: DMA access complete, dma_rdata valid.
- dma_rdata  out  32  DMA read data.
- mem_en, mem_we  out  1 each  DM enable / write strobe.
- mem_addr, mem_wdata, mem_pc  out  32 each  DM command, driven from latched registers.
- mem_rdata  in  32  DM read data, valid on the last busy cycle.

## Operation
- States: IDLE, BUSY_M, BUSY_D. Busy-cycle counter cnt runs 0..LAT-1. Starvation counter scnt is 4 bits.
- IDLE arbitration:
  - m_req && (!dma_req || scnt<STARVE_MAX) → BUSY_M. If dma_req is also high, scnt++ (saturate at STARVE_MAX).
  - Else dma_req → BUSY_D, dma_gnt=1, scnt←0.
  - Neither → stay in IDLE.
- On grant, latch addr/wdata/we (and m_pc for pipeline; 0 for DMA) into command registers. cnt←0.
- Busy: mem_en=1 every busy cycle. mem_we=we_reg only when cnt==0, so exactly one write per store. cnt++ each cycle.
- Completion when cnt==LAT-1:
  - BUSY_M: m_done=1, m_rdata=mem_rdata.
  - BUSY_D: dma_done=1, dma_rdata=mem_rdata.
  - Then → IDLE unconditionally; there is no back-to-back grant without an IDLE cycle.
- m_stall = m_req && !m_done, combinational.
  - Stall also covers a pipeline request waiting in IDLE or during BUSY_D.
- m_rdata/dma_rdata pass mem_rdata through combinationally, qualified by done. Value outside done is don't-care, but the bench checks it is driven.
- When idle, mem_en=0, mem_we=0, and mem_addr/wdata/pc hold their last latched values.

## Timing
- Reset values: state=IDLE, cnt=0, scnt=0, command registers=0, m_stall=m_req, all other outputs 0.
- Pipeline access: request in IDLE at cycle t → busy t+1..t+LAT, done at t+LAT.
  - m_stall is high t..t+LAT-1 and low at t+LAT.
  - Total occupancy is LAT+1 cycles.
- DMA access: dma_gnt at t, dma_done at t+LAT.
- Simultaneous requests in IDLE resolve by priority. A new request arriving during busy waits for IDLE.
- Deassertion of m_req/dma_req mid-busy is illegal. The access completes from the latched command regardless.
- Reset mid-busy: immediate return to IDLE, no done pulse. A write already issued at cnt==0 is not rolled back.
- LAT=1: busy is a single cycle; mem_we and done coincide.

## Test plan
- Pipeline load, LAT=2, addr 0x0000_0010, mem_rdata=0xDEAD_BEEF on the last busy cycle → m_stall high 2 cycles, m_rdata=0xDEAD_BEEF on the 3rd cycle, mem_we never high.
- Pipeline store, addr 0x4, wdata 0x1234_5678, pc 0x3000 → exactly one mem_we cycle with the latched values, m_stall released at cnt==1.
- m_req and dma_req held continuously, STARVE_MAX=4 → 4 pipeline accesses, then dma_gnt. scnt returns to 0 and the pattern repeats.
- DMA read while the pipeline is idle, addr 0x20 → dma_gnt at t, dma_done plus data at t+2. A pipeline m_req arriving at t+1 is stalled until DMA completes and its own access finishes (done at t+5).
- Assert reset during BUSY_M cnt==1 → state IDLE immediately, no m_done, scnt=0, mem_en=0. A request after release is served normally.
- Sweep LAT=1 and LAT=4 with back-to-back loads → stall lengths of 1 and 4 cycles respectively, with one IDLE gap between accesses.
